// File: rtl/chime_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chime_scheduler
// Purpose  : Hourly chime / alarm scheduler for a digital clock. An accepted
//            hour pulse flashes LED N times (N = hour on a 12-hour dial),
//            one second high per flash. An alarm match gates the buzzer for
//            ALARM_TICKS seconds and preempts any chime. A chime request
//            that arrives during an alarm is held and run after the alarm.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ALARM_TICKS : Tick_1Hz periods an alarm sounds (even, 2..127)
//   CNT_W       : tick counter width, holds max(ALARM_TICKS, 24)
// Ports
//   CP          : in  1  system clock, rising edge
//   nCR         : in  1  asynchronous active-low reset
//   Tick_1Hz    : in  1  one-cycle pulse once per second
//   Hour_Pulse  : in  1  one-cycle pulse at the top of each hour
//   Hour        : in  5  current hour 0..23, valid with Hour_Pulse
//   Alarm_Match : in  1  one-cycle pulse when alarm time is reached
//   Alarm_Stop  : in  1  one-cycle user pulse silencing the alarm
//   Chime_En    : in  1  level, enables hourly chime
//   Alarm_En    : in  1  level, enables alarm
//   LED         : out 1  chime flash
//   Buzzer      : out 1  alarm tone gate
//   Busy        : out 1  state is not IDLE
//   Mode        : out 2  00 IDLE, 01 CHIME, 10 ALARM
// ============================================================================
module chime_scheduler #(
  parameter int ALARM_TICKS = 60,
  parameter int CNT_W       = 7
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       Tick_1Hz,
  input  logic       Hour_Pulse,
  input  logic [4:0] Hour,
  input  logic       Alarm_Match,
  input  logic       Alarm_Stop,
  input  logic       Chime_En,
  input  logic       Alarm_En,
  output logic       LED,
  output logic       Buzzer,
  output logic       Busy,
  output logic [1:0] Mode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHIME = 2'b01,
    S_ALARM = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] c_alarm_cnt = CNT_W'(ALARM_TICKS);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic [3:0]       r_pend_n, w_pend_n_nxt;
  logic             r_led, w_led_nxt;
  logic             r_buz, w_buz_nxt;

  logic [3:0]       w_n;
  logic             w_chime_req;
  logic             w_alarm_req;
  logic             w_pend_eff;
  logic [3:0]       w_pend_n_eff;
  logic             w_alarm_exit;

  // Hour to flash count on a 12-hour dial; value is don't-care for hour > 23
  // because such pulses are never accepted.
  always_comb begin
    w_n = 4'd12;
    if (Hour == 5'd0)
      w_n = 4'd12;
    else if (Hour <= 5'd12)
      w_n = Hour[3:0];
    else
      w_n = 4'(Hour - 5'd12);
  end

  assign w_chime_req = Hour_Pulse && Chime_En && (Hour <= 5'd23);
  assign w_alarm_req = Alarm_Match && Alarm_En;

  // A request arriving in the very cycle the alarm ends still counts as held.
  assign w_pend_eff   = r_pend || w_chime_req;
  assign w_pend_n_eff = w_chime_req ? w_n : r_pend_n;

  // Stop (or alarm disable) wins over a same-cycle tick.
  assign w_alarm_exit = Alarm_Stop || !Alarm_En || (Tick_1Hz && (r_cnt == c_cnt_one));

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_pend_n <= 4'd0;
      r_led    <= 1'b0;
      r_buz    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_n <= w_pend_n_nxt;
      r_led    <= w_led_nxt;
      r_buz    <= w_buz_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_pend;
    w_pend_n_nxt = r_pend_n;
    w_led_nxt    = r_led;
    w_buz_nxt    = r_buz;

    if (w_alarm_req) begin
      // Alarm preempts everything; an interrupted chime is dropped.
      w_state_nxt = S_ALARM;
      w_cnt_nxt   = c_alarm_cnt;
      w_led_nxt   = 1'b0;
      w_buz_nxt   = 1'b0;
      if (w_chime_req) begin
        w_pend_nxt   = 1'b1;
        w_pend_n_nxt = w_n;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_chime_req) begin
            w_state_nxt = S_CHIME;
            w_cnt_nxt   = CNT_W'({w_n, 1'b0});
            w_led_nxt   = 1'b0;
          end
        end

        S_CHIME: begin
          if (!Chime_En) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_led_nxt   = 1'b0;
          end else if (w_chime_req) begin
            w_cnt_nxt = CNT_W'({w_n, 1'b0});
            w_led_nxt = 1'b0;
          end else if (Tick_1Hz) begin
            if (r_cnt == c_cnt_one) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_led_nxt   = 1'b0;
            end else begin
              w_cnt_nxt = r_cnt - c_cnt_one;
              w_led_nxt = ~r_led;
            end
          end
        end

        S_ALARM: begin
          if (w_chime_req) begin
            w_pend_nxt   = 1'b1;
            w_pend_n_nxt = w_n;
          end
          if (w_alarm_exit) begin
            w_buz_nxt  = 1'b0;
            w_pend_nxt = 1'b0;
            if (w_pend_eff && Chime_En) begin
              w_state_nxt = S_CHIME;
              w_cnt_nxt   = CNT_W'({w_pend_n_eff, 1'b0});
              w_led_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end else if (Tick_1Hz) begin
            w_cnt_nxt = r_cnt - c_cnt_one;
            w_buz_nxt = ~r_buz;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_led_nxt   = 1'b0;
          w_buz_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign LED    = r_led;
  assign Buzzer = r_buz;
  assign Busy   = (r_state != S_IDLE);
  assign Mode   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_chime_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_chime_scheduler
// Purpose  : Directed self-checking bench for chime_scheduler. Each step
//            pushes the expected {Mode,Busy,LED,Buzzer} onto a scoreboard
//            queue, which is popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chime_scheduler;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       Tick_1Hz = 1'b0;
  logic       Hour_Pulse = 1'b0;
  logic [4:0] Hour = 5'd0;
  logic       Alarm_Match = 1'b0;
  logic       Alarm_Stop = 1'b0;
  logic       Chime_En = 1'b0;
  logic       Alarm_En = 1'b0;
  logic       LED;
  logic       Buzzer;
  logic       Busy;
  logic [1:0] Mode;

  localparam logic [1:0] c_idle  = 2'b00;
  localparam logic [1:0] c_chime = 2'b01;
  localparam logic [1:0] c_alarm = 2'b10;

  chime_scheduler #(.ALARM_TICKS(60), .CNT_W(7)) u_dut (
    .CP          (CP),
    .nCR         (nCR),
    .Tick_1Hz    (Tick_1Hz),
    .Hour_Pulse  (Hour_Pulse),
    .Hour        (Hour),
    .Alarm_Match (Alarm_Match),
    .Alarm_Stop  (Alarm_Stop),
    .Chime_En    (Chime_En),
    .Alarm_En    (Alarm_En),
    .LED         (LED),
    .Buzzer      (Buzzer),
    .Busy        (Busy),
    .Mode        (Mode)
  );

  always #5 CP = ~CP;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Expected vector: {Mode, Busy, LED, Buzzer}
  task automatic push(input string tag, input logic [1:0] md, input logic led, input logic buz);
    exp_t e;
    e.tag = tag;
    e.val = {md, (md != 2'b00), led, buz};
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [4:0] obs;
    obs = {Mode, Busy, LED, Buzzer};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %b required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed {Mode,Busy,LED,Buzzer}=%b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock cycle: inputs set at the falling edge, pulses dropped and
  // outputs sampled 1 time unit after the rising edge.
  task automatic cyc(input logic hp, input logic [4:0] hr, input logic am,
                     input logic stp, input logic tk);
    @(negedge CP);
    Hour_Pulse  = hp;
    Hour        = hr;
    Alarm_Match = am;
    Alarm_Stop  = stp;
    Tick_1Hz    = tk;
    @(posedge CP);
    #1;
    Hour_Pulse  = 1'b0;
    Alarm_Match = 1'b0;
    Alarm_Stop  = 1'b0;
    Tick_1Hz    = 1'b0;
  endtask

  // Full chime: pulse then 2n ticks, each followed by an idle cycle.
  task automatic chime_run(input string tag, input logic [4:0] hr, input int n);
    logic led_e;
    cyc(1'b1, hr, 1'b0, 1'b0, 1'b0);
    push({tag, "_start"}, c_chime, 1'b0, 1'b0); check_out();
    for (int k = 1; k <= 2 * n; k++) begin
      led_e = (k % 2) == 1;
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push($sformatf("%s_tick%0d", tag, k), (k == 2 * n) ? c_idle : c_chime, led_e, 1'b0);
      check_out();
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      push($sformatf("%s_hold%0d", tag, k), (k == 2 * n) ? c_idle : c_chime, led_e, 1'b0);
      check_out();
    end
  endtask

  initial begin
    // Reset state
    #2;
    push("reset_state", c_idle, 1'b0, 1'b0); check_out();
    @(negedge CP);
    nCR      = 1'b1;
    Chime_En = 1'b1;
    Alarm_En = 1'b1;
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("idle_tick", c_idle, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    push("idle_stop_ignored", c_idle, 1'b0, 1'b0); check_out();

    // Hour 15 -> 3 flashes, 0 -> 12, 12 -> 12
    chime_run("h15", 5'd15, 3);
    chime_run("h0", 5'd0, 12);
    chime_run("h12", 5'd12, 12);

    // Out-of-range hour and disabled chime are ignored
    cyc(1'b1, 5'd25, 1'b0, 1'b0, 1'b0);
    push("h25_ignored", c_idle, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("h25_tick", c_idle, 1'b0, 1'b0); check_out();
    Chime_En = 1'b0;
    cyc(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    push("chime_dis_ignored", c_idle, 1'b0, 1'b0); check_out();
    Chime_En = 1'b1;

    // Alarm preempts a Hour=5 chime on its 2nd tick; 30 buzzer highs
    cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    push("pre_start", c_chime, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("pre_tick1", c_chime, 1'b1, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    push("pre_alarm", c_alarm, 1'b0, 1'b0); check_out();
    for (int k = 1; k <= 60; k++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push($sformatf("alarm_tick%0d", k), (k == 60) ? c_idle : c_alarm, 1'b0, (k % 2) == 1);
      check_out();
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push($sformatf("no_resume%0d", k), c_idle, 1'b0, 1'b0); check_out();
    end

    // Hour 14 pulse during alarm is held, then Alarm_Stop -> 2 flashes
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push("pend_alarm", c_alarm, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("pend_tick1", c_alarm, 1'b0, 1'b1); check_out();
    cyc(1'b1, 5'd14, 1'b0, 1'b0, 1'b0);
    push("pend_hour", c_alarm, 1'b0, 1'b1); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    push("pend_stop", c_chime, 1'b0, 1'b0); check_out();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push($sformatf("pend_flash%0d", k), (k == 4) ? c_idle : c_chime, (k % 2) == 1, 1'b0);
      check_out();
    end

    // Alarm_Stop with Tick in the same cycle: no toggle, exit
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push("st_alarm", c_alarm, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("st_tick", c_alarm, 1'b0, 1'b1); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    push("st_stop_tick", c_idle, 1'b0, 1'b0); check_out();

    // Alarm_En low in alarm acts as stop; pending chime dropped if Chime_En=0
    cyc(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    push("dis_alarm", c_alarm, 1'b0, 1'b0); check_out();
    Chime_En = 1'b0;
    Alarm_En = 1'b0;
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push("dis_exit", c_idle, 1'b0, 1'b0); check_out();
    Chime_En = 1'b1;
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    push("alarm_en_off_match", c_idle, 1'b0, 1'b0); check_out();
    Alarm_En = 1'b1;

    // Chime_En dropped mid-chime
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    push("cd_start", c_chime, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("cd_tick", c_chime, 1'b1, 1'b0); check_out();
    Chime_En = 1'b0;
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    push("cd_exit", c_idle, 1'b0, 1'b0); check_out();
    Chime_En = 1'b1;

    // Asynchronous reset mid-chime, no clock edge involved
    cyc(1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    push("rst_start", c_chime, 1'b0, 1'b0); check_out();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    push("rst_tick", c_chime, 1'b1, 1'b0); check_out();
    nCR = 1'b0;
    #1;
    push("rst_async", c_idle, 1'b0, 1'b0); check_out();
    #1;
    nCR = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push($sformatf("rst_after%0d", k), c_idle, 1'b0, 1'b0); check_out();
    end

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chime_scheduler.md
CHIME_SCHEDULER -- requirements
Module: chime_scheduler

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 60: number of Tick_1Hz periods an alarm sounds; must be even, 2..127.
REQ-002 SHALL have parameter CNT_W, default 7: width of the internal tick counter; must hold max(ALARM_TICKS, 24).
REQ-003 SHALL have port CP, input, 1: system clock; all state changes on its rising edge.
REQ-004 SHALL have port nCR, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port Tick_1Hz, input, 1: one-CP-cycle pulse, once per second.
REQ-006 SHALL have port Hour_Pulse, input, 1: one-CP-cycle pulse at the top of each hour.
REQ-007 SHALL have port Hour, input, 5: current hour, binary 0..23, valid when Hour_Pulse=1.
REQ-008 SHALL have port Alarm_Match, input, 1: one-CP-cycle pulse when the alarm time is reached.
REQ-009 SHALL have port Alarm_Stop, input, 1: one-CP-cycle user pulse that silences the alarm.
REQ-010 SHALL have port Chime_En, input, 1: level; 1 enables the hourly chime.
REQ-011 SHALL have port Alarm_En, input, 1: level; 1 enables the alarm.
REQ-012 SHALL have port LED, output, 1: chime flash output.
REQ-013 SHALL have port Buzzer, output, 1: alarm tone gate.
REQ-014 SHALL have port Busy, output, 1: 1 when state is not IDLE.
REQ-015 SHALL have port Mode, output, 2: state code: 00 IDLE, 01 CHIME, 10 ALARM.

Function
REQ-016 SHALL implement FSM states IDLE, CHIME and ALARM, plus a 1-bit Pend_Chime flag and a CNT_W-bit down-counter Cnt.
REQ-017 SHALL compute flash count N from the sampled Hour: 0 gives 12; 1..12 gives Hour; 13..23 gives Hour-12.
REQ-018 SHALL ignore Hour_Pulse when Hour is greater than 23 or Chime_En is 0.
REQ-019 SHALL, in IDLE on an accepted Hour_Pulse, enter CHIME on the next CP edge with Cnt=2N and LED=0.
REQ-020 SHALL, in CHIME on each Tick_1Hz, invert LED and decrement Cnt; at Cnt=1 it SHALL also go to IDLE, so LED ends at 0 after exactly N high periods of one second each.
REQ-021 SHALL, in any state on Alarm_Match with Alarm_En=1, enter ALARM with Cnt=ALARM_TICKS, Buzzer=0 and LED=0.
REQ-022 SHALL, in ALARM on each Tick_1Hz, invert Buzzer and decrement Cnt; at Cnt=1 it SHALL go to IDLE with Buzzer=0.
REQ-023 SHALL, when ALARM preempts CHIME, abort the chime and not resume it.
REQ-024 SHALL, on an accepted Hour_Pulse during ALARM, or in the same cycle as an accepted Alarm_Match, set Pend_Chime and latch N; only one request is held and a later one overwrites N.
REQ-025 SHALL, on leaving ALARM with Pend_Chime=1 and Chime_En=1, enter CHIME directly with Cnt=2N and clear Pend_Chime; with Chime_En=0 it SHALL clear Pend_Chime and go to IDLE.
REQ-026 SHALL, when Alarm_Stop=1 in ALARM, leave ALARM on the next edge with Buzzer=0, then follow REQ-025.
REQ-027 SHALL, in CHIME, treat Hour_Pulse as a restart with the new N.
REQ-028 SHALL, when Chime_En=0 during CHIME, go to IDLE on the next edge with LED=0.
REQ-029 SHALL, when Alarm_En=0 during ALARM, behave as Alarm_Stop.
REQ-030 SHALL let Alarm_Stop take priority over a Tick_1Hz in the same cycle.
REQ-031 SHALL ignore Alarm_Stop outside ALARM.
REQ-032 SHALL keep Tick_1Hz from affecting LED or Buzzer in IDLE.
REQ-033 SHALL hold LED=0 whenever the state is not CHIME, and Buzzer=0 whenever the state is not ALARM.

Reset
REQ-034 SHALL, while nCR=0, immediately force IDLE, Cnt=0, Pend_Chime=0, LED=0, Buzzer=0, Busy=0 and Mode=00, regardless of CP.
REQ-035 SHALL, after release of nCR mid-chime or mid-alarm, not resume the aborted activity; it SHALL wait for the next request.

Verification
REQ-036 SHALL be checked by: Chime_En=1, Hour_Pulse with Hour=15 -> Mode=01, 3 LED high pulses of 1 Tick each, 6 ticks total, then IDLE with LED=0.
REQ-037 SHALL be checked by: Hour=0 -> 12 flashes; Hour=12 -> 12 flashes; Hour=25 -> no response, Busy stays 0.
REQ-038 SHALL be checked by: Alarm_Match at the 2nd tick of a Hour=5 chime -> LED=0, Mode=10, 30 Buzzer high periods (ALARM_TICKS=60), then IDLE, and the chime is not resumed.
REQ-039 SHALL be checked by: Hour_Pulse (Hour=14) during ALARM, then Alarm_Stop -> Buzzer=0 on the next edge, then Mode=01 with 2 flashes.
REQ-040 SHALL be checked by: Alarm_Stop and Tick_1Hz in the same cycle -> no toggle, Buzzer=0, exit ALARM.
REQ-041 SHALL be checked by: nCR pulsed low mid-chime, with no CP edge -> outputs 0 immediately; after release, further Ticks produce no LED activity.
